isqrt_engine: RTL and testbench

Parametrised sequential integer square-root unit: computes floor(sqrt(din)) and the remainder din − root² for an unsigned WIDTH-bit operand. It combines controller and datapath in one block and supports two run-time selectable algorithms: linear odd-number accumulation (latency depends on the data) and restoring digit-by-digit (fixed latency). It sits behind a start/busy/done handshake, so a host FSM can issue one operation at a time.

---
 rtl/sqrt_pkg.sv | 20 ++
 rtl/isqrt_digit_step.sv | 31 +++
 rtl/isqrt_engine.sv | 128 ++++++++++++
 tb/tb_isqrt_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the integer square-root engine.
// Kept free of parameters so any WIDTH instance can import it.
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LIN,
    DIG,
    DONE
  } state_t;

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

  function automatic int cnt_w(input int w);
    return $clog2(w / 2) + 1;
  endfunction

endpackage

// File: rtl/isqrt_digit_step.sv
// One restoring digit-by-digit square-root iteration (one bit-pair).
// Purely combinational; the engine registers its outputs.
module isqrt_digit_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH/2+1:0] rm,
  input  logic [WIDTH/2+1:0] r,
  input  logic [1:0]         pair,
  output logic [WIDTH/2+1:0] rm_n,
  output logic [WIDTH/2+1:0] r_n
);
  import sqrt_pkg::*;

  localparam int SW = half_w(WIDTH) + 2;

  logic [SW-1:0] rm_p;
  logic [SW-1:0] trial;

  always_comb begin
    rm_p  = (rm << 2) | SW'(pair);
    trial = (r << 2) | SW'(1);
    if (rm_p >= trial) begin
      rm_n = rm_p - trial;
      r_n  = (r << 1) | SW'(1);
    end else begin
      rm_n = rm_p;
      r_n  = r << 1;
    end
  end

endmodule

// File: rtl/isqrt_engine.sv
// Sequential integer square root with a start/busy/done handshake.
// mode 0: odd-number accumulation, mode 1: restoring digit-by-digit.
module isqrt_engine #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               mode,
  input  logic [WIDTH-1:0]   din,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] root,
  output logic [WIDTH/2:0]   rem
);
  import sqrt_pkg::*;

  localparam int HALF = half_w(WIDTH);
  localparam int CW   = cnt_w(WIDTH);
  localparam int SW   = HALF + 2;
  localparam int OW   = HALF + 1;

  generate
    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
      $error("isqrt_engine: WIDTH must be even and >= 4");
    end
  endgenerate

  state_t st_q;
  state_t st_d;

  logic [WIDTH-1:0] lin_r;
  logic [WIDTH-1:0] lin_rm;
  logic [OW-1:0]    odd;
  logic             lin_ge;

  logic [SW-1:0]    dig_r;
  logic [SW-1:0]    dig_rm;
  logic [SW-1:0]    step_r;
  logic [SW-1:0]    step_rm;
  logic [WIDTH-1:0] dig_sh;
  logic [CW-1:0]    cnt;
  logic             dig_last;

  assign lin_ge   = lin_rm >= WIDTH'(odd);
  assign dig_last = cnt == CW'(HALF - 1);

  assign busy = (st_q == LIN) || (st_q == DIG);
  assign done = (st_q == DONE);

  isqrt_digit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rm   (dig_rm),
    .r    (dig_r),
    .pair (dig_sh[WIDTH-1 -: 2]),
    .rm_n (step_rm),
    .r_n  (step_r)
  );

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: if (start) st_d = mode ? DIG : LIN;
      LIN:  if (!lin_ge) st_d = DONE;
      DIG:  if (dig_last) st_d = DONE;
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Results only move on the final iteration edge, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (clr) begin
      root   <= '0;
      rem    <= '0;
      lin_r  <= '0;
      lin_rm <= '0;
      odd    <= '0;
      dig_r  <= '0;
      dig_rm <= '0;
      dig_sh <= '0;
      cnt    <= '0;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (start) begin
            lin_r  <= '0;
            lin_rm <= din;
            odd    <= OW'(1);
            dig_r  <= '0;
            dig_rm <= '0;
            dig_sh <= din;
            cnt    <= '0;
          end
        end
        LIN: begin
          if (lin_ge) begin
            lin_rm <= lin_rm - WIDTH'(odd);
            odd    <= odd + OW'(2);
            lin_r  <= lin_r + WIDTH'(1);
          end else begin
            root <= lin_r[HALF-1:0];
            rem  <= lin_rm[HALF:0];
          end
        end
        DIG: begin
          dig_rm <= step_rm;
          dig_r  <= step_r;
          dig_sh <= dig_sh << 2;
          cnt    <= cnt + CW'(1);
          if (dig_last) begin
            root <= step_r[HALF-1:0];
            rem  <= step_rm[HALF:0];
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_engine.sv
// Self-checking bench for isqrt_engine (WIDTH=16): cycle model plus
// directed vectors with hand-computed roots and latencies.
module tb_isqrt_engine;

  localparam int W = 16;
  localparam int H = W / 2;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic         mode;
  logic [W-1:0] din;
  logic         busy;
  logic         done;
  logic [H-1:0] root;
  logic [H:0]   rem;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  isqrt_engine #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .mode  (mode),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .root  (root),
    .rem   (rem)
  );

  always #5 clk = ~clk;

  function automatic int fsqrt(input int x);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= x) s++;
    return s;
  endfunction

  // Transaction-level model: result from arithmetic, latency from formula.
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  logic [H-1:0] m_root = '0;
  logic [H:0]   m_rem  = '0;
  int m_left = 0;
  int p_root = 0;
  int p_rem  = 0;
  int cap    = 0;

  always @(posedge clk) begin
    if (clr) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_root = '0;
      m_rem  = '0;
      m_left = 0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_root = H'(p_root);
        m_rem  = (H+1)'(p_rem);
      end
    end else if (start) begin
      cap    = int'(din);
      p_root = fsqrt(cap);
      p_rem  = cap - p_root * p_root;
      m_left = mode ? H : p_root + 1;
      m_busy = 1'b1;
    end
  end

  int pr;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if ({busy, done, root, rem} !== {m_busy, m_done, m_root, m_rem}) begin
        failures++;
        $display("FAIL cycle t=%0t got busy=%b done=%b root=%0d rem=%0d want busy=%b done=%b root=%0d rem=%0d",
                 $time, busy, done, root, rem, m_busy, m_done, m_root, m_rem);
      end
      if (done) begin
        checks++;
        pr = int'(root);
        if (!(pr * pr <= cap && cap < (pr + 1) * (pr + 1) &&
              int'(rem) == cap - pr * pr)) begin
          failures++;
          $display("FAIL sqrt_prop din=%0d got root=%0d rem=%0d", cap, root, rem);
        end
      end
    end
  end

  task automatic run_op(input bit md, input logic [W-1:0] d,
                        input int er, input int erem,
                        input int elat, input int pulse_at);
    int k;
    int lat;
    lat = (elat >= 0) ? elat : (md ? H : fsqrt(int'(d)) + 1);
    @(negedge clk);
    start = 1'b1;
    mode  = md;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    mode  = ~md;
    din   = d ^ 16'h5A5A;
    k = 0;
    while (!done && k < 400) begin
      if (k + 1 == pulse_at) begin
        start = 1'b1;
        mode  = 1'b1;
        din   = 16'd4;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    checks++;
    if (!done || k != lat) begin
      failures++;
      $display("FAIL latency din=%0d mode=%0d got edge=%0d done=%b want edge=%0d",
               d, md, k, done, lat);
    end
    if (er >= 0) begin
      checks++;
      if (root !== H'(er) || rem !== (H+1)'(erem)) begin
        failures++;
        $display("FAIL literal din=%0d mode=%0d got root=%0d rem=%0d want root=%0d rem=%0d",
                 d, md, root, rem, er, erem);
      end
    end
  endtask

  bit saw_done;

  initial begin
    clr   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    clr    = 1'b0;

    checks++;
    if ({busy, done, root, rem} !== '0) begin
      failures++;
      $display("FAIL reset got busy=%b done=%b root=%0d rem=%0d want 0",
               busy, done, root, rem);
    end

    run_op(1'b1, 16'hFFFF, 255, 510, 8, -1);
    run_op(1'b0, 16'd26, 5, 1, 6, -1);
    run_op(1'b1, 16'd26, 5, 1, 8, -1);
    run_op(1'b0, 16'd0, 0, 0, 1, -1);
    run_op(1'b1, 16'd0, 0, 0, 8, -1);
    run_op(1'b0, 16'd1, 1, 0, 2, -1);
    run_op(1'b0, 16'hFFFF, 255, 510, 256, -1);
    run_op(1'b1, 16'd48, 6, 12, 8, -1);
    run_op(1'b0, 16'd10000, 100, 0, 101, 3);

    // Abort a DIG run with clr at edge 4.
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    din   = 16'd50000;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, root, rem} !== '0) begin
      failures++;
      $display("FAIL clr_abort got busy=%b done=%b root=%0d rem=%0d want 0",
               busy, done, root, rem);
    end
    clr = 1'b0;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL no_done_after_clr got done=1 want 0");
    end
    run_op(1'b1, 16'd49, 7, 0, 8, -1);

    // clr and start together: start is dropped.
    @(negedge clk);
    clr   = 1'b1;
    start = 1'b1;
    mode  = 1'b0;
    din   = 16'd81;
    @(negedge clk);
    clr   = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || root !== '0) begin
      failures++;
      $display("FAIL clr_start got busy=%b root=%0d want busy=0 root=0", busy, root);
    end
    run_op(1'b0, 16'd81, 9, 0, 10, -1);

    for (int i = 0; i < 120; i++) begin
      run_op(1'b1, W'($urandom), -1, 0, -1, -1);
      run_op(1'b0, W'($urandom), -1, 0, -1, -1);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
